// File: rtl/rom_image_loader.sv
// rom_image_loader: fills a block-RAM image from a valid/ready byte stream,
// then reads every written word back through the synchronous read port and
// compares the wrapped sum of what came back with the sum of what was written.
module rom_image_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_enable,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    // Image size, one bit wider than the address so a full image is representable.
    localparam logic [ADDR_WIDTH:0] SIZE = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] rsum_q, rsum_d;
    logic                  pending_q, pending_d;
    logic                  last_word;

    // count_q has reached the final word of the image being loaded or read.
    assign last_word = (count_q == (len_q - ONE));

    // State register and counters; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            rsum_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            rsum_q    <= rsum_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic plus the memory/stream strobes, all decoded from state.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        sum_d       = sum_q;
        rsum_d      = rsum_q;
        pending_d   = 1'b0;
        s_ready     = 1'b0;
        mem_we      = 1'b0;
        mem_enable  = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;

        // A read issued last cycle has its data on mem_rdata now.
        if (pending_q) begin
            rsum_d = rsum_q + mem_rdata;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    sum_d   = '0;
                    rsum_d  = '0;
                    count_d = '0;
                    if (length == '0) begin
                        state_d = ST_DONE;
                    end else if (length > SIZE) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD;
                        len_d   = length;
                    end
                end
            end

            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    mem_we      = 1'b1;
                    mem_address = count_q[ADDR_WIDTH-1:0];
                    mem_wdata   = s_data;
                    sum_d       = sum_q + s_data;
                    if (last_word) begin
                        state_d = ST_VERIFY;
                        count_d = '0;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
            end

            ST_VERIFY: begin
                mem_enable  = 1'b1;
                mem_address = count_q[ADDR_WIDTH-1:0];
                pending_d   = 1'b1;
                if (last_word) begin
                    state_d = ST_CHECK;
                    count_d = '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end

            ST_CHECK: begin
                if (rsum_d == sum_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ERROR;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == ST_LOAD) || (state_q == ST_VERIFY) || (state_q == ST_CHECK);
    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERROR);
    assign checksum = sum_q;

endmodule

// File: tb/tb_rom_image_loader.sv
// Bench for rom_image_loader: a timeline model (writes, then L reads, one
// check cycle, then the verdict) predicts every output each cycle, and a
// handful of literal expectations pin the model to hand-computed values.
module tb_rom_image_loader;

    localparam int AW   = 6;
    localparam int DW   = 8;
    localparam int SIZE = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   length;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_enable;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] checksum;

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;

    rom_image_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .length(length),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_enable(mem_enable), .mem_rdata(mem_rdata), .busy(busy),
        .done(done), .error(error), .checksum(checksum)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory array with synchronous read and an optional corrupted location.
    logic [DW-1:0] mem [0:SIZE-1];
    int            wr_count     = 0;
    int            wr_last_addr = 0;
    bit            corrupt_en   = 1'b0;
    int            corrupt_addr = 0;
    logic [DW-1:0] corrupt_val  = '0;

    always @(posedge clock) begin
        if (mem_we) begin
            mem[mem_address] <= mem_wdata;
            wr_count         <= wr_count + 1;
            wr_last_addr     <= int'(mem_address);
        end
        if (mem_enable) begin
            mem_rdata <= (corrupt_en && int'(mem_address) == corrupt_addr) ? corrupt_val : mem[mem_address];
        end
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Reference model: loading flag, words written, cycles since last write, verdict.
    logic [DW-1:0] exp_mem [0:SIZE-1];
    bit            m_loading   = 1'b0;
    int            m_len       = 0;
    int            m_nw        = 0;
    int            m_since     = -1;
    int            m_result    = 0;
    logic [DW-1:0] m_wsum      = '0;
    bit            m_sum_known = 1'b1;

    function automatic bit model_verdict();
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < m_len; i++) begin
            s = s + ((corrupt_en && i == corrupt_addr) ? corrupt_val : exp_mem[i]);
        end
        return s == m_wsum;
    endfunction

    always @(posedge clock or posedge reset) begin
        bit busy_now;
        if (reset) begin
            m_loading   = 1'b0;
            m_len       = 0;
            m_nw        = 0;
            m_since     = -1;
            m_result    = 0;
            m_wsum      = '0;
            m_sum_known = 1'b1;
        end else begin
            busy_now = m_loading || (m_since >= 1);
            if (m_since >= 1) begin
                m_since++;
                if (m_since == m_len + 2) begin
                    m_result = model_verdict() ? 1 : 2;
                    m_since  = -1;
                end
            end
            if (m_loading && s_valid) begin
                exp_mem[m_nw] = s_data;
                m_wsum        = m_wsum + s_data;
                m_nw++;
                if (m_nw == m_len) begin
                    m_loading = 1'b0;
                    m_since   = 1;
                end
            end
            if (start && !busy_now) begin
                if (length == 0) begin
                    m_result    = 1;
                    m_wsum      = '0;
                    m_sum_known = 1'b1;
                end else if (int'(length) > SIZE) begin
                    m_result    = 2;
                    m_sum_known = 1'b0;
                end else begin
                    m_result    = 0;
                    m_loading   = 1'b1;
                    m_len       = int'(length);
                    m_nw        = 0;
                    m_wsum      = '0;
                    m_sum_known = 1'b1;
                end
            end
        end
    end

    // Every cycle, compare all DUT outputs with the model's prediction.
    always @(negedge clock) begin
        bit exp_we;
        bit exp_en;
        int exp_addr;
        exp_we   = m_loading && s_valid;
        exp_en   = (m_since >= 1) && (m_since <= m_len);
        exp_addr = exp_we ? m_nw : (exp_en ? m_since - 1 : 0);
        check_output("s_ready", 32'(s_ready), 32'(m_loading));
        check_output("mem_we", 32'(mem_we), 32'(exp_we));
        check_output("mem_enable", 32'(mem_enable), 32'(exp_en));
        check_output("mem_address", 32'(mem_address), 32'(exp_addr));
        check_output("mem_wdata", 32'(mem_wdata), exp_we ? 32'(s_data) : 32'd0);
        check_output("busy", 32'(busy), 32'(m_loading || (m_since >= 1)));
        check_output("done", 32'(done), 32'(m_result == 1));
        check_output("error", 32'(error), 32'(m_result == 2));
        check_output("we_en_exclusive", 32'(mem_we & mem_enable), 32'd0);
        if (m_sum_known) begin
            check_output("checksum", 32'(checksum), 32'(m_wsum));
        end
    end

    logic [DW-1:0] stim_data [0:SIZE-1];

    // Pulse start, stream the words in stim_data, then wait for a verdict.
    task automatic apply_stimulus(input int len, input int mode, input int abort_after,
                                  output int xfer_cyc, output int res_cyc);
        int n_acc;
        int k;
        int budget;
        n_acc    = 0;
        k        = 0;
        xfer_cyc = -1;
        res_cyc  = -1;
        @(posedge clock); #1;
        start  = 1'b1;
        length = (AW + 1)'(len);
        budget = len * 8 + 50;
        while (n_acc < len && budget > 0) begin
            @(posedge clock); #1;
            if (abort_after > 0 && n_acc == abort_after) begin
                start   = 1'b0;
                s_valid = 1'b0;
                #1;
                reset = 1'b1;
                #1;
                check_output("rst_s_ready", 32'(s_ready), 32'd0);
                check_output("rst_mem_we", 32'(mem_we), 32'd0);
                check_output("rst_mem_enable", 32'(mem_enable), 32'd0);
                check_output("rst_mem_address", 32'(mem_address), 32'd0);
                check_output("rst_mem_wdata", 32'(mem_wdata), 32'd0);
                check_output("rst_checksum", 32'(checksum), 32'd0);
                check_output("rst_busy", 32'(busy), 32'd0);
                check_output("rst_done", 32'(done), 32'd0);
                check_output("rst_error", 32'(error), 32'd0);
                @(posedge clock); #3;
                reset = 1'b0;
                return;
            end
            start  = (mode == 2 && $urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            length = (AW + 1)'($urandom_range(0, SIZE + 1));
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (k % 2 == 0);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            s_data = stim_data[n_acc];
            k++;
            budget--;
            #1;
            if (s_valid && s_ready) begin
                n_acc++;
                xfer_cyc = cyc;
            end
        end
        if (n_acc < len) begin
            check_output("stream_timeout", 32'(n_acc), 32'(len));
        end
        @(posedge clock); #1;
        start   = 1'b0;
        s_valid = 1'b0;
        budget  = 4 * len + 40;
        while (!(done || error) && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        if (done || error) begin
            res_cyc = cyc;
        end else begin
            check_output("result_timeout", 32'd0, 32'd1);
        end
    endtask

    // Start with a length that never enters LOAD; returns one cycle later.
    task automatic start_only(input int len);
        @(posedge clock); #1;
        start  = 1'b1;
        length = (AW + 1)'(len);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    initial begin
        int xc;
        int rc;
        int wb;
        int len;
        reset   = 1'b1;
        start   = 1'b0;
        length  = '0;
        s_data  = '0;
        s_valid = 1'b0;
        for (int i = 0; i < SIZE; i++) mem[i] = '0;
        repeat (2) @(posedge clock);
        #3;
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;

        $display("[TB] back-to-back load of 4 words");
        for (int i = 0; i < 4; i++) stim_data[i] = DW'(i + 1);
        wb = wr_count;
        apply_stimulus(4, 0, 0, xc, rc);
        check_output("t1_checksum", 32'(checksum), 32'h0A);
        check_output("t1_done", 32'(done), 32'd1);
        check_output("t1_error", 32'(error), 32'd0);
        check_output("t1_latency", 32'(rc - xc), 32'd6);
        check_output("t1_writes", 32'(wr_count - wb), 32'd4);

        $display("[TB] toggling valid");
        wb = wr_count;
        apply_stimulus(4, 1, 0, xc, rc);
        check_output("t2_checksum", 32'(checksum), 32'h0A);
        check_output("t2_done", 32'(done), 32'd1);
        check_output("t2_writes", 32'(wr_count - wb), 32'd4);

        $display("[TB] corrupted readback");
        stim_data[0] = 8'hFF;
        stim_data[1] = 8'hFF;
        stim_data[2] = 8'h03;
        corrupt_en   = 1'b1;
        corrupt_addr = 1;
        corrupt_val  = 8'hFE;
        apply_stimulus(3, 0, 0, xc, rc);
        check_output("t3_checksum", 32'(checksum), 32'h01);
        check_output("t3_error", 32'(error), 32'd1);
        check_output("t3_done", 32'(done), 32'd0);
        corrupt_en = 1'b0;

        $display("[TB] zero and oversize length");
        wb = wr_count;
        start_only(0);
        check_output("t4_len0_done", 32'(done), 32'd1);
        check_output("t4_len0_checksum", 32'(checksum), 32'd0);
        start_only(SIZE + 1);
        check_output("t4_big_error", 32'(error), 32'd1);
        check_output("t4_big_done", 32'(done), 32'd0);
        check_output("t4_no_writes", 32'(wr_count - wb), 32'd0);

        $display("[TB] full-size image");
        for (int i = 0; i < SIZE; i++) stim_data[i] = DW'(i);
        wb = wr_count;
        apply_stimulus(SIZE, 0, 0, xc, rc);
        check_output("t5_last_addr", 32'(wr_last_addr), 32'(SIZE - 1));
        check_output("t5_writes", 32'(wr_count - wb), 32'(SIZE));
        check_output("t5_done", 32'(done), 32'd1);
        check_output("t5_latency", 32'(rc - xc), 32'(SIZE + 2));

        $display("[TB] reset mid-load");
        for (int i = 0; i < 8; i++) stim_data[i] = DW'($urandom);
        apply_stimulus(8, 0, 2, xc, rc);
        stim_data[0] = 8'h10;
        stim_data[1] = 8'h22;
        apply_stimulus(2, 0, 0, xc, rc);
        check_output("t6_done", 32'(done), 32'd1);
        check_output("t6_checksum", 32'(checksum), 32'h32);

        $display("[TB] randomized loads");
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(1, SIZE);
            for (int i = 0; i < len; i++) stim_data[i] = DW'($urandom);
            corrupt_en   = ($urandom_range(0, 3) == 0);
            corrupt_addr = $urandom_range(0, len - 1);
            corrupt_val  = DW'($urandom);
            apply_stimulus(len, 2, 0, xc, rc);
        end
        corrupt_en = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/rom_image_loader.md
Name: rom_image_loader

Overview:
- Writer-side counterpart of the synchronous-read ROM block: fills a block-RAM image from an incoming byte stream, then reads it back to verify.
- Sits between the host/flash byte source and the cartridge memory array at boot, before the bus side is released.
- Write phase accepts a valid/ready byte stream and writes sequential addresses from 0.
- Verify phase reads every written address back through the memory's 1-cycle synchronous read port and compares sums.

Parameters:
- ADDR_WIDTH, 14, memory address width; image size SIZE = 2^ADDR_WIDTH.
- DATA_WIDTH, 8, memory/stream word width.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when state is IDLE, DONE or ERROR; ignored otherwise.
- length  in  ADDR_WIDTH+1  words to load; sampled on accepted start.
- s_data  in  DATA_WIDTH  stream word.
- s_valid  in  1  stream word present.
- s_ready  out  1  loader accepts word this cycle.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_we  out  1  write strobe.
- mem_enable  out  1  read enable; rdata valid the cycle after.
- mem_rdata  in  DATA_WIDTH  synchronous read data.
- busy  out  1  high in LOAD/VERIFY/CHECK.
- done  out  1  level, high in DONE.
- error  out  1  level, high in ERROR.
- checksum  out  DATA_WIDTH  modulo-2^DATA_WIDTH sum of words written.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including s_ready, mem_we, mem_enable, mem_address, mem_wdata, checksum, done and error; internal counters 0.
- States: IDLE, LOAD, VERIFY, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - length == 0 -> DONE next cycle, checksum=0.
  - length > SIZE -> ERROR next cycle.
  - otherwise -> LOAD; count=0, sum=0, rsum=0; done/error cleared.
- LOAD:
  - s_ready=1 combinationally while in LOAD.
  - Transfer on s_valid&&s_ready. The same cycle drives mem_we=1, mem_address=count, mem_wdata=s_data.
  - Writes are combinational from the transfer, so they land on that edge. sum += s_data, count++.
  - s_valid low: no write, no count change, mem_we=0.
  - After transfer with count==length-1 -> VERIFY, count=0. s_ready=0 from the next cycle.
- VERIFY:
  - Each cycle with count<length: mem_enable=1, mem_address=count, count++.
  - A registered "pending" flag marks that rdata is valid next cycle. rsum += mem_rdata on each pending cycle.
  - After the last issue -> CHECK, so the last read returns in CHECK.
- CHECK (one cycle): add the final rdata; compare. Equal -> DONE, else -> ERROR.
- checksum output holds sum and updates continuously during LOAD. In DONE/ERROR it shows the write-side sum.
- Verification uses the 2^DATA_WIDTH wrapped sum. Compensating errors are not detected; this is accepted.
- start during LOAD/VERIFY/CHECK is ignored; no restart mid-operation.
- length == SIZE: address wraps only after the last write; no address beyond SIZE-1 is issued.
- Reset mid-LOAD aborts immediately; memory contents are undefined; a new start is required.
- mem_we and mem_enable are never high in the same cycle.
- Latency:
  - Start to first s_ready: 1 cycle.
  - Last transfer to done (no verify mismatch): length+2 cycles.

Test Plan:
- Reset then start, length=4, stream 0x01,0x02,0x03,0x04 back-to-back, memory model echoes writes:
  - 4 writes at addresses 0..3; s_ready=1 for 4 cycles.
  - Reads 0..3, then done=1 at 6 cycles after the last transfer; checksum=0x0A; error=0.
- Same stream with s_valid toggling 1,0,1,0:
  - Writes occur only on valid cycles; addresses remain contiguous 0..3.
  - checksum=0x0A; done=1.
- length=3, stream 0xFF,0xFF,0x03, memory model corrupts address 1 to 0xFE on readback:
  - checksum=0x01; error=1, done=0.
- length=0 -> done=1 one cycle after start, no mem_we. length=2^ADDR_WIDTH+1 -> error=1, no writes.
- length=2^ADDR_WIDTH with incrementing data: last write at address SIZE-1; no wrap write to 0 before VERIFY; done=1.
- Assert reset mid-LOAD after 2 of 8 words:
  - All outputs 0 asynchronously.
  - A subsequent start with length=2 completes normally with done=1.
